// File: rtl/display_scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the multiplexed 7-segment scan driver.
//   DEFAULT_DIGIT_W : default width of one digit code
//   BLANK_DIGIT     : digit code presented while nothing has been loaded yet
//   page_w()        : width of a page selector, never narrower than one bit
//   on_cycles()     : number of lit cycles in the drive phase of a slot
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int DEFAULT_DIGIT_W = 4;
   localparam int BLANK_DIGIT     = 0;

   // A single page still needs a one-bit selector so ports never collapse
   // to zero width.
   function automatic int page_w(input int num_pages);
      return (num_pages <= 1) ? 1 : $clog2(num_pages);
   endfunction

   // The lit portion of the drive phase scales linearly with brightness+1.
   // The product is formed at 64 bits so no high bits are lost before the
   // shift; an all-ones brightness code gives the full drive phase.
   function automatic int unsigned on_cycles(input int unsigned slot,
                                             input int unsigned guard,
                                             input int unsigned bright,
                                             input int unsigned bw);
      longint unsigned prod;
      prod = 64'(slot - guard) * 64'(bright + 1);
      return 32'(prod >> bw);
   endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// ---------------------------------------------------------------------------
// display_scan_mux_if
// Bundles the digit sources from the calculator datapath and the anode /
// segment-decoder signals of the scan driver.
//   digits      : NUM_PAGES*NUM_DIGITS digit codes, page p digit i at p*NUM_DIGITS+i
//   dp_mask     : decimal point request per digit, same indexing
//   blank_mask  : per-position forced dark
//   lz_suppress : enable leading-zero suppression
//   page_sel    : requested page
//   brightness  : PWM code, 0 = dimmest, all ones = full on
//   an          : anode enables, active low
//   digit_out   : digit code for the segment decoder
//   dp_n        : decimal point, active low
//   frame_start : one-cycle pulse at the start of each frame
//   active_page : page currently shown
// master = datapath side, slave = scan driver.
// ---------------------------------------------------------------------------
interface display_scan_mux_if
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_PAGES  = 2,
   parameter int DIGIT_W    = DEFAULT_DIGIT_W,
   parameter int BRIGHT_W   = 4
);

   localparam int PAGE_W = page_w(NUM_PAGES);

   logic [NUM_PAGES*NUM_DIGITS*DIGIT_W-1:0] digits;
   logic [NUM_PAGES*NUM_DIGITS-1:0]         dp_mask;
   logic [NUM_DIGITS-1:0]                   blank_mask;
   logic                                    lz_suppress;
   logic [PAGE_W-1:0]                       page_sel;
   logic [BRIGHT_W-1:0]                     brightness;
   logic [NUM_DIGITS-1:0]                   an;
   logic [DIGIT_W-1:0]                      digit_out;
   logic                                    dp_n;
   logic                                    frame_start;
   logic [PAGE_W-1:0]                       active_page;

   modport master (
      output digits, dp_mask, blank_mask, lz_suppress, page_sel, brightness,
      input  an, digit_out, dp_n, frame_start, active_page
   );

   modport slave (
      input  digits, dp_mask, blank_mask, lz_suppress, page_sel, brightness,
      output an, digit_out, dp_n, frame_start, active_page
   );

endinterface

// File: rtl/display_scan_mux_timer.sv
// ---------------------------------------------------------------------------
// display_scan_timer
// Slot/position counters for the display scan.
//   clk, rst_n  : clock, synchronous active-low reset
//   cnt         : cycle within the current digit slot, 0..SLOT_CYCLES-1
//   idx         : position being scanned, 0..NUM_DIGITS-1
//   guard       : high while cnt is inside the anodes-off guard interval
//   frame_end   : high in the last cycle of a frame (idx and cnt both at max)
//   frame_first : high in the first cycle of a frame (idx and cnt both zero)
// ---------------------------------------------------------------------------
module display_scan_timer #(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 2048,
   parameter int GUARD_CYCLES = 16,
   parameter int CNT_W        = $clog2(SLOT_CYCLES),
   parameter int IDX_W        = (NUM_DIGITS <= 2) ? 1 : $clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] idx,
   output logic             guard,
   output logic             frame_end,
   output logic             frame_first
);

   logic cnt_last;
   logic idx_last;

   // Terminal-count decodes shared by the counter and the frame strobes.
   always_comb begin
      cnt_last = (cnt == CNT_W'(SLOT_CYCLES - 1));
      idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
   end

   // cnt runs through one slot; on its wrap the scan moves to the next
   // position, and after the last position it returns to position 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt_last) begin
         cnt <= '0;
         idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Phase and frame-boundary flags, all derived from the current state.
   always_comb begin
      guard       = (32'(cnt) < 32'(GUARD_CYCLES));
      frame_end   = cnt_last && idx_last;
      frame_first = (cnt == '0) && (idx == '0);
   end

endmodule

// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------
// display_scan_mux
// Time-multiplexed driver for a common-anode 7-segment array. Scans
// NUM_DIGITS positions of one of NUM_PAGES digit pages, with per-position
// decimal point, blanking, leading-zero suppression, a per-slot guard
// interval with all anodes off, and PWM brightness within each slot.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : display_scan_mux_if.slave
//                inputs  digits, dp_mask, blank_mask, lz_suppress, page_sel,
//                        brightness (all sampled only at frame boundaries)
//                outputs an, digit_out, dp_n, frame_start, active_page
//                        (registered, one cycle behind the scan state)
// ---------------------------------------------------------------------------
module display_scan_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int NUM_PAGES    = 2,
   parameter int DIGIT_W      = DEFAULT_DIGIT_W,
   parameter int SLOT_CYCLES  = 2048,
   parameter int GUARD_CYCLES = 16,
   parameter int BRIGHT_W     = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   display_scan_mux_if.slave   bus
);

   localparam int PAGE_W = page_w(NUM_PAGES);
   localparam int CNT_W  = $clog2(SLOT_CYCLES);
   localparam int IDX_W  = (NUM_DIGITS <= 2) ? 1 : $clog2(NUM_DIGITS);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             guard;
   logic             frame_end;
   logic             frame_first;

   logic [NUM_PAGES*NUM_DIGITS*DIGIT_W-1:0] sh_digits;
   logic [NUM_PAGES*NUM_DIGITS-1:0]         sh_dp;
   logic [NUM_DIGITS-1:0]                   sh_blank;
   logic [BRIGHT_W-1:0]                     sh_bright;
   logic                                    sh_lz;
   logic [PAGE_W-1:0]                       sh_page;

   logic [PAGE_W-1:0]  page_clamped;
   logic [DIGIT_W-1:0] page_digit [NUM_DIGITS];
   logic               page_dp    [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] suppressed;
   logic [NUM_DIGITS-1:0] visible;
   logic               zero_run;
   logic [31:0]        on_len;
   logic [31:0]        drive_pos;
   logic               lit;
   logic [NUM_DIGITS-1:0] an_next;

   logic [NUM_DIGITS-1:0] an_q;
   logic [DIGIT_W-1:0]    digit_q;
   logic                  dp_n_q;
   logic                  frame_start_q;
   logic [PAGE_W-1:0]     active_page_q;

   display_scan_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .SLOT_CYCLES  (SLOT_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES),
      .CNT_W        (CNT_W),
      .IDX_W        (IDX_W)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .cnt         (cnt),
      .idx         (idx),
      .guard       (guard),
      .frame_end   (frame_end),
      .frame_first (frame_first)
   );

   // A request for a page that does not exist shows the highest real page
   // rather than reading past the end of the digit array.
   always_comb begin
      page_clamped = bus.page_sel;
      if (32'(bus.page_sel) >= 32'(NUM_PAGES)) begin
         page_clamped = PAGE_W'(NUM_PAGES - 1);
      end
   end

   // Everything the scan displays comes from this shadow set, reloaded only
   // on the edge that closes a frame, so a frame is never a mix of old and
   // new inputs. Reset leaves every position blanked, so the first frame
   // after reset is dark.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_digits <= '0;
         sh_dp     <= '0;
         sh_blank  <= '1;
         sh_bright <= '0;
         sh_lz     <= 1'b0;
         sh_page   <= '0;
      end else if (frame_end) begin
         sh_digits <= bus.digits;
         sh_dp     <= bus.dp_mask;
         sh_blank  <= bus.blank_mask;
         sh_bright <= bus.brightness;
         sh_lz     <= bus.lz_suppress;
         sh_page   <= page_clamped;
      end
   end

   // Pick out the digits and decimal points of the page being displayed.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         page_digit[i] = sh_digits[(int'(sh_page) * NUM_DIGITS + i) * DIGIT_W +: DIGIT_W];
         page_dp[i]    = sh_dp[int'(sh_page) * NUM_DIGITS + i];
      end
   end

   // Leading-zero suppression walks down from the most significant position:
   // a position stays dark only while it and everything above it is zero
   // with no decimal point. Position 0 always shows so a value of zero
   // still reads "0".
   always_comb begin
      suppressed = '0;
      zero_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (page_digit[i] == '0) && !page_dp[i];
         suppressed[i] = sh_lz && zero_run;
      end
      visible = ~sh_blank & ~suppressed;
   end

   // After the guard interval the anode of the scanned position is held low
   // for on_len cycles and then released for the rest of the slot.
   always_comb begin
      on_len    = on_cycles(SLOT_CYCLES, GUARD_CYCLES, 32'(sh_bright), BRIGHT_W);
      drive_pos = 32'(cnt) - 32'(GUARD_CYCLES);
      lit       = !guard && visible[idx] && (drive_pos < on_len);
      an_next   = '1;
      if (lit) begin
         an_next[idx] = 1'b0;
      end
   end

   // All outputs are registered from the current scan state, so they trail
   // the counters by one cycle; frame_start therefore marks the cycle whose
   // outputs belong to position 0, cycle 0, and active_page changes on that
   // same cycle together with the new page's digits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_q          <= '1;
         digit_q       <= DIGIT_W'(BLANK_DIGIT);
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
         active_page_q <= '0;
      end else begin
         an_q          <= an_next;
         digit_q       <= page_digit[idx];
         dp_n_q        <= !(lit && page_dp[idx]);
         frame_start_q <= frame_first;
         active_page_q <= sh_page;
      end
   end

   assign bus.an          = an_q;
   assign bus.digit_out   = digit_q;
   assign bus.dp_n        = dp_n_q;
   assign bus.frame_start = frame_start_q;
   assign bus.active_page = active_page_q;

endmodule
